// File: rtl/core_wb_arbiter_bridge.sv
// core_wb_arbiter_bridge: N-port core request arbiter onto one Wishbone classic master,
// with fixed or round-robin arbitration and an optional bus timeout reported as an error.
`default_nettype none

module core_wb_arbiter_bridge #(
    parameter int NUM_PORTS      = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int ARB_MODE       = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_PORTS-1:0]              req_read_i,
    input  logic [NUM_PORTS-1:0]              req_write_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] req_sel_i,
    output logic [DATA_WIDTH-1:0]             req_rdata_o,
    output logic [NUM_PORTS-1:0]              req_resp_o,
    output logic [NUM_PORTS-1:0]              req_err_o,
    output logic                              wb_cyc_o,
    output logic                              wb_stb_o,
    output logic                              wb_we_o,
    output logic [ADDR_WIDTH-1:0]             wb_addr_o,
    output logic [DATA_WIDTH-1:0]             wb_data_o,
    output logic [DATA_WIDTH/8-1:0]           wb_sel_o,
    input  logic [DATA_WIDTH-1:0]             wb_data_i,
    input  logic                              wb_ack_i,
    output logic                              busy_o
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nx;
    logic [NUM_PORTS-1:0]   requesting;
    logic                   any_req;
    logic                   found;
    logic [IDX_WIDTH-1:0]   cand;
    logic [IDX_WIDTH-1:0]   winner;
    logic [IDX_WIDTH-1:0]   grant;
    logic [IDX_WIDTH-1:0]   last_grant;
    logic [CNT_WIDTH-1:0]   cnt;
    logic                   err_flag;
    logic                   timeout_hit;

    assign requesting  = req_read_i | req_write_i;
    assign any_req     = |requesting;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
    assign busy_o      = (state == BUS) || (state == RESP);

    // Round-robin scans from the port after the last one granted; fixed scans from 0.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (ARB_MODE == 1)
                cand = IDX_WIDTH'((int'(last_grant) + 1 + k) % NUM_PORTS);
            else
                cand = IDX_WIDTH'(k);
            if (!found && requesting[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        req_resp_o = '0;
        req_err_o  = '0;
        case (state)
            IDLE: if (any_req) state_nx = BUS;
            BUS:  if (wb_ack_i || timeout_hit) state_nx = RESP;
            RESP: begin
                state_nx          = IDLE;
                req_resp_o[grant] = 1'b1;
                req_err_o[grant]  = err_flag;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant       <= '0;
            last_grant  <= IDX_WIDTH'(NUM_PORTS - 1);
            cnt         <= '0;
            err_flag    <= 1'b0;
            req_rdata_o <= '0;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            wb_addr_o   <= '0;
            wb_data_o   <= '0;
            wb_sel_o    <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant      <= winner;
                        last_grant <= winner;
                        cnt        <= '0;
                        wb_cyc_o   <= 1'b1;
                        wb_stb_o   <= 1'b1;
                        wb_we_o    <= req_write_i[winner];
                        wb_addr_o  <= req_addr_i[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
                        wb_data_o  <= req_wdata_i[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
                        wb_sel_o   <= req_sel_i[int'(winner)*SEL_WIDTH +: SEL_WIDTH];
                    end
                end
                BUS: begin
                    // An ack on the terminal timeout cycle still wins.
                    if (wb_ack_i) begin
                        req_rdata_o <= wb_data_i;
                        err_flag    <= 1'b0;
                        wb_cyc_o    <= 1'b0;
                        wb_stb_o    <= 1'b0;
                    end else if (timeout_hit) begin
                        req_rdata_o <= '1;
                        err_flag    <= 1'b1;
                        wb_cyc_o    <= 1'b0;
                        wb_stb_o    <= 1'b0;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/core_wb_arbiter_bridge.md
# core_wb_arbiter_bridge

Parametrised bridge from N core-style memory ports (level read/write request, one-cycle response pulse) onto a single Wishbone classic master interface. It is the multi-port successor to the single-port read/write-to-cyc/stb/we glue between a core and the Controller bus. It adds byte selects, fixed or round-robin arbitration, and a bus timeout that returns an error instead of hanging the core. It sits between the core (instruction and data ports) and the Controller's core bus.

## Interface
- NUM_PORTS, 2: number of requester ports, 1..8.
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 32: data width, multiple of 8.
- ARB_MODE, 0: 0 = fixed priority (lowest index wins); 1 = round-robin.
- TIMEOUT_CYCLES, 255: maximum number of BUS cycles without ack; 0 disables the timeout.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_read_i  in  NUM_PORTS  level read request per port.
- req_write_i  in  NUM_PORTS  level write request per port.
- req_addr_i  in  NUM_PORTS*ADDR_WIDTH  packed; port p occupies [p*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata_i  in  NUM_PORTS*DATA_WIDTH  packed write data.
- req_sel_i  in  NUM_PORTS*DATA_WIDTH/8  packed byte selects.
- req_rdata_o  out  DATA_WIDTH  shared read data; valid while the port's req_resp_o is high.
- req_resp_o  out  NUM_PORTS  one-cycle completion pulse per port.
- req_err_o  out  NUM_PORTS  error pulse, coincident with req_resp_o on timeout.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone control.
- wb_addr_o  out  ADDR_WIDTH; wb_data_o  out  DATA_WIDTH; wb_sel_o  out  DATA_WIDTH/8.
- wb_data_i  in  DATA_WIDTH; wb_ack_i  in  1.
- busy_o  out  1  high in BUS or RESP.

## Operation
- A port is requesting when req_read_i[p] | req_write_i[p]. If both are high, the access is a write.
- A requester holds its request, address, data and sel stable until its req_resp_o pulse. At the edge where it samples req_resp_o high, it either drops the request or presents the next one.

FSM states IDLE, BUS and RESP:
- IDLE: if any port is requesting, select a winner and register its address, data, sel, we and grant index. Start the timeout counter at 0 and go to BUS.
- BUS: wb_cyc_o = wb_stb_o = 1.
  - When wb_ack_i is sampled high, capture wb_data_i into req_rdata_o and go to RESP with no error.
  - If the timeout counter reaches TIMEOUT_CYCLES-1 without an ack, drop cyc/stb, set req_rdata_o to all ones, and go to RESP with error. The counter saturates; it does not wrap.
- RESP: req_resp_o[grant] = 1 and req_err_o[grant] = error for exactly one cycle, then go to IDLE.

Arbitration:
- Fixed mode: lowest requesting index wins.
- Round-robin mode: search starts at last_grant+1 modulo NUM_PORTS. last_grant updates when a grant is issued.
- Arbitration happens only in IDLE. Requests arriving during BUS/RESP wait; they are never dropped.

Other rules:
- wb_ack_i outside BUS is ignored. An ack coincident with the timeout terminal cycle counts as success.
- All wb_* outputs are registered. req_rdata_o holds its last value between responses.
- Requester addresses are passed through unmodified. No alignment check.

## Timing
- Reset (async assert): all outputs 0, including wb_cyc_o/wb_stb_o, req_resp_o, req_err_o and req_rdata_o. FSM goes to IDLE and last_grant = NUM_PORTS-1, so port 0 is first in round-robin.
- Reset mid-transaction aborts the cycle immediately. No response is issued.
- Zero-wait slave:
  - request seen at edge 0;
  - cyc/stb high in cycle 1, ack in cycle 1;
  - resp in cycle 2;
  - IDLE in cycle 3.
- With zero-wait ack, back-to-back throughput is one transaction per 3 cycles. Each wait state adds 1 cycle.
- Timeout: cyc stays high for exactly TIMEOUT_CYCLES cycles, followed by one error-resp cycle.
- TIMEOUT_CYCLES = 0: wait for ack indefinitely.

## Test plan
- Single read, port 0, addr 0x100, slave returns 0xDEADBEEF with zero wait -> cyc high 1 cycle, we=0, sel=0xF, resp[0] pulse in cycle 2 with rdata 0xDEADBEEF, err=0.
- Write from port 1, addr 0x204, data 0x12345678, sel 0x3, ack after 2 wait states -> wb_we_o=1, data/sel match, cyc held 3 cycles, resp[1] single pulse.
- Both ports request continuously, ARB_MODE=1 -> grant sequence 0,1,0,1. With ARB_MODE=0 -> grant sequence 0,0,0 until port 0 drops.
- No ack, TIMEOUT_CYCLES=4 -> cyc high exactly 4 cycles, then resp and err pulse together with rdata 0xFFFFFFFF. The next request proceeds normally.
- rst_n asserted while cyc is high -> cyc/stb/resp go to 0 asynchronously, no resp pulse, and round-robin restarts at port 0.
- Spurious wb_ack_i in IDLE, and read+write asserted together -> ack ignored; the combined request is issued as a write.
